// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: FFT result stream into the peak detector and its power/peak outputs.
//   in_fft_data_flag/in_fft_data : {I,Q} bin stream from the FFT core, one bin per cycle
//   pwr_valid/pwr_data/pwr_bin   : per-bin power I^2+Q^2 with its bin index
//   peak_valid/peak_bin/peak_power : end-of-frame maximum report pulse
//   frame_err                    : pulse on an aborted frame
//   master = stream source/sink side, slave = detector side
interface fft_peak_detect_if #(
  parameter int N          = 64,
  parameter int DATA_WIDTH = 8
);
  localparam int BW = $clog2(N);
  localparam int PW = 2*DATA_WIDTH+1;
  logic                    in_fft_data_flag;
  logic [2*DATA_WIDTH-1:0] in_fft_data;
  logic                    pwr_valid;
  logic [PW-1:0]           pwr_data;
  logic [BW-1:0]           pwr_bin;
  logic                    peak_valid;
  logic [BW-1:0]           peak_bin;
  logic [PW-1:0]           peak_power;
  logic                    frame_err;
  modport master (
    output in_fft_data_flag, in_fft_data,
    input  pwr_valid, pwr_data, pwr_bin, peak_valid, peak_bin, peak_power, frame_err
  );
  modport slave (
    input  in_fft_data_flag, in_fft_data,
    output pwr_valid, pwr_data, pwr_bin, peak_valid, peak_bin, peak_power, frame_err
  );
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin power of an FFT frame plus strongest-bin report per frame.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fft_peak_detect_if (input stream, power stream, peak report)
module fft_peak_detect #(
  parameter int N           = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int SKIP_DC     = 1,
  parameter int BIT_REVERSE = 0
) (
  input logic             clk,
  input logic             rst_n,
  fft_peak_detect_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int BW = $clog2(N);
  localparam int PW = 2*DW+1;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REPORT, ABORT} state_t;
  state_t state, nxt;
  logic [BW-1:0] cnt;
  logic [1:0] dcnt;
  logic flag, last, acc, kill;
  logic s1_v, s1_t, s2_v, s2_t, s3_v, s3_t;
  logic signed [2*DW-1:0] s1_i, s1_q;
  logic [2*DW-1:0] s2_ii, s2_qq;
  logic [PW-1:0] s3_p, t_p, hold_p;
  logic [BW-1:0] s1_b, s2_b, s3_b, t_b, hold_b;
  logic t_has, take;
  function automatic logic [BW-1:0] rev(input logic [BW-1:0] x);
    for (int k = 0; k < BW; k++) rev[k] = x[BW-1-k];
  endfunction
  assign flag = bus.in_fft_data_flag;
  assign last = flag && cnt == BW'(N-1);
  // every flagged bin is counted except during the one-cycle abort
  assign acc  = flag && state != ABORT;
  assign kill = nxt == ABORT;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = flag ? ACCUM : IDLE;
      ACCUM:   nxt = !flag ? ABORT : last ? DRAIN : ACCUM;
      DRAIN:   nxt = dcnt == 2'd2 ? REPORT : DRAIN;
      REPORT:  nxt = last ? DRAIN : (flag || cnt != '0) ? ACCUM : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      state <= nxt;
      cnt   <= kill ? '0 : acc ? cnt + 1'b1 : cnt;
      dcnt  <= state == DRAIN ? dcnt + 1'b1 : '0;
    end
  // s*_t marks bins that belong to a tracked frame; an abort strips it from bins still in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1_v, s1_t, s2_v, s2_t, s3_v, s3_t} <= '0;
      {s1_i, s1_q, s2_ii, s2_qq, s3_p} <= '0;
      {s1_b, s2_b, s3_b} <= '0;
    end else begin
      s1_v  <= flag;
      s1_t  <= acc;
      s1_i  <= {{DW{bus.in_fft_data[2*DW-1]}}, bus.in_fft_data[2*DW-1:DW]};
      s1_q  <= {{DW{bus.in_fft_data[DW-1]}}, bus.in_fft_data[DW-1:0]};
      s1_b  <= BIT_REVERSE != 0 ? rev(cnt) : cnt;
      s2_v  <= s1_v;
      s2_t  <= s1_t && !kill;
      s2_ii <= s1_i * s1_i;
      s2_qq <= s1_q * s1_q;
      s2_b  <= s1_b;
      s3_v  <= s2_v;
      s3_t  <= s2_t && !kill;
      s3_p  <= {1'b0, s2_ii} + {1'b0, s2_qq};
      s3_b  <= s2_b;
    end
  // reversal maps only index 0 to 0, so the DC test works on either index form
  assign take = s3_v && s3_t && !(SKIP_DC != 0 && s3_b == '0);
  // REPORT publishes the tracker and seeds it with a next-frame bin leaving the pipeline that cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t_has  <= 1'b0;
      t_b    <= '0;
      t_p    <= '0;
      hold_b <= '0;
      hold_p <= '0;
    end else if (state == REPORT) begin
      hold_b <= t_b;
      hold_p <= t_p;
      t_has  <= take;
      t_b    <= take ? s3_b : '0;
      t_p    <= take ? s3_p : '0;
    end else if (state == ABORT) begin
      t_has <= 1'b0;
      t_b   <= '0;
      t_p   <= '0;
    end else if (take && (!t_has || s3_p > t_p)) begin
      t_has <= 1'b1;
      t_b   <= s3_b;
      t_p   <= s3_p;
    end
  assign bus.pwr_valid  = s3_v;
  assign bus.pwr_data   = s3_p;
  assign bus.pwr_bin    = s3_b;
  assign bus.peak_valid = state == REPORT;
  assign bus.peak_bin   = state == REPORT ? t_b : hold_b;
  assign bus.peak_power = state == REPORT ? t_p : hold_p;
  assign bus.frame_err  = state == ABORT;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: directed checks of fft_peak_detect across DC-skip and bit-reverse variants.
module tb_fft_peak_detect;
  logic clk = 1'b0;
  logic rst_n;
  logic flag;
  logic [15:0] data;
  logic [15:0] vec [128];
  int cyc = 0, npass = 0, ntot = 0;
  int m_cyc, l_cyc, base_pk, base_err, base_pwr;
  int npk [3];
  int nerr = 0, npwr = 0;
  int pw_val [64];
  int pw_cyc [64];
  logic pv [3];
  logic [5:0] pb [3];
  logic [16:0] pp [3];
  logic [5:0] pbl [3], pbp [3];
  logic [16:0] ppl [3], ppp [3];
  int pcl [3], pcp [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fft_peak_detect_if #(.N(64), .DATA_WIDTH(8)) b0 ();
  fft_peak_detect_if #(.N(64), .DATA_WIDTH(8)) b1 ();
  fft_peak_detect_if #(.N(64), .DATA_WIDTH(8)) b2 ();
  assign b0.in_fft_data_flag = flag;
  assign b1.in_fft_data_flag = flag;
  assign b2.in_fft_data_flag = flag;
  assign b0.in_fft_data = data;
  assign b1.in_fft_data = data;
  assign b2.in_fft_data = data;
  fft_peak_detect #(.N(64), .DATA_WIDTH(8), .SKIP_DC(1), .BIT_REVERSE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fft_peak_detect #(.N(64), .DATA_WIDTH(8), .SKIP_DC(0), .BIT_REVERSE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  fft_peak_detect #(.N(64), .DATA_WIDTH(8), .SKIP_DC(1), .BIT_REVERSE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign pv[0] = b0.peak_valid;
  assign pv[1] = b1.peak_valid;
  assign pv[2] = b2.peak_valid;
  assign pb[0] = b0.peak_bin;
  assign pb[1] = b1.peak_bin;
  assign pb[2] = b2.peak_bin;
  assign pp[0] = b0.peak_power;
  assign pp[1] = b1.peak_power;
  assign pp[2] = b2.peak_power;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (pv[k]) begin
        npk[k] <= npk[k] + 1;
        pbp[k] <= pbl[k];
        pbl[k] <= pb[k];
        ppp[k] <= ppl[k];
        ppl[k] <= pp[k];
        pcp[k] <= pcl[k];
        pcl[k] <= cyc;
      end
    if (b0.frame_err) nerr <= nerr + 1;
    if (b0.pwr_valid) begin
      npwr <= npwr + 1;
      pw_val[b0.pwr_bin] <= int'(b0.pwr_data);
      pw_cyc[b0.pwr_bin] <= cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic clear_vec();
    for (int i = 0; i < 128; i++) vec[i] = 16'h0000;
  endtask
  task automatic drive(input int n, input int mark);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flag = 1'b1;
      data = vec[i];
      if (i == mark) m_cyc = cyc;
      l_cyc = cyc;
    end
    @(negedge clk);
    flag = 1'b0;
    data = 16'h0000;
  endtask
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    flag  = 1'b0;
    data  = 16'h0000;
    settle(3);
    chk("rst_pwr_valid", b0.pwr_valid, 0);
    chk("rst_pwr_data", b0.pwr_data, 0);
    chk("rst_pwr_bin", b0.pwr_bin, 0);
    chk("rst_peak_valid", b0.peak_valid, 0);
    chk("rst_peak_bin", b0.peak_bin, 0);
    chk("rst_peak_power", b0.peak_power, 0);
    chk("rst_frame_err", b0.frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flag = 1'b1;
      data = 16'h3200;
    end
    @(negedge clk);
    flag  = 1'b0;
    data  = 16'h0000;
    rst_n = 1'b0;
    #1;
    chk("midrst_pwr_valid", b0.pwr_valid, 0);
    chk("midrst_pwr_data", b0.pwr_data, 0);
    chk("midrst_peak_valid", b0.peak_valid, 0);
    base_pk  = npk[0];
    base_err = nerr;
    @(negedge clk);
    rst_n = 1'b1;
    clear_vec();
    vec[17] = 16'h03FC;
    drive(64, 17);
    settle(10);
    chk("clean_peak_count", npk[0] - base_pk, 1);
    chk("clean_err_count", nerr - base_err, 0);
    chk("b17_peak_bin", pbl[0], 17);
    chk("b17_peak_power", ppl[0], 25);
    chk("b17_pwr_data", pw_val[17], 25);
    chk("b17_pwr_latency", pw_cyc[17] - m_cyc, 3);
    chk("b17_peak_latency", pcl[0] - l_cyc, 4);
    chk("b17_nodc_bin", pbl[1], 17);
    chk("b17_rev_bin", pbl[2], 34);
    chk("b17_rev_power", ppl[2], 25);
    clear_vec();
    vec[5] = 16'h8080;
    drive(64, 5);
    settle(10);
    chk("ext_pwr_data", pw_val[5], 32768);
    chk("ext_peak_power", ppl[0], 32768);
    chk("ext_peak_bin", pbl[0], 5);
    chk("ext_rev_bin", pbl[2], 40);
    clear_vec();
    vec[0]  = 16'h6400;
    vec[40] = 16'h0A00;
    vec[41] = 16'h0A00;
    drive(64, 0);
    settle(10);
    chk("skipdc_bin", pbl[0], 40);
    chk("skipdc_power", ppl[0], 100);
    chk("withdc_bin", pbl[1], 0);
    chk("withdc_power", ppl[1], 10000);
    chk("skipdc_rev_bin", pbl[2], 5);
    base_pk  = npk[0];
    base_err = nerr;
    base_pwr = npwr;
    clear_vec();
    vec[3] = 16'h7F7F;
    drive(30, 0);
    settle(10);
    chk("abort_err_count", nerr - base_err, 1);
    chk("abort_peak_count", npk[0] - base_pk, 0);
    chk("abort_pwr_count", npwr - base_pwr, 30);
    chk("abort_hold_bin", b0.peak_bin, 40);
    chk("abort_hold_power", b0.peak_power, 100);
    base_pk  = npk[0];
    base_err = nerr;
    clear_vec();
    vec[1]  = 16'h0007;
    vec[64] = 16'h0600;
    vec[73] = 16'hFB00;
    drive(128, 0);
    settle(10);
    chk("b2b_peak_count", npk[0] - base_pk, 2);
    chk("b2b_err_count", nerr - base_err, 0);
    chk("b2b_spacing", pcl[0] - pcp[0], 64);
    chk("b2b_a_bin", pbp[0], 1);
    chk("b2b_a_power", ppp[0], 49);
    chk("b2b_b_bin", pbl[0], 9);
    chk("b2b_b_power", ppl[0], 25);
    chk("b2b_nodc_a_bin", pbp[1], 1);
    chk("b2b_nodc_b_bin", pbl[1], 0);
    chk("b2b_nodc_b_power", ppl[1], 36);
    chk("b2b_rev_a_bin", pbp[2], 32);
    chk("b2b_rev_b_bin", pbl[2], 36);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Sits directly downstream of the radix-2 FFT core and consumes its {I,Q} result stream.
- Computes the power of every bin as I² + Q² and streams it out with a bin index.
- Tracks the strongest bin across one N-bin frame and reports that bin index and its power once the frame completes.
- Result feeds the downstream tone or carrier detection logic.

Parameters:
- N, 64, FFT points per frame; power of two, ≥4.
- DATA_WIDTH, 8, width of each signed I and Q component.
- SKIP_DC, 1, when 1 bin 0 is excluded from the peak search; it is still streamed on pwr_*.
- BIT_REVERSE, 0, when 1 the reported bin indices are the bit-reversed arrival index; when 0 they are the arrival index.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_fft_data_flag  in  1  high while in_fft_data carries a valid bin; one bin per cycle.
- in_fft_data  in  2*DATA_WIDTH  {I[2*DW-1:DW], Q[DW-1:0]}, both two's complement.
- pwr_valid  out  1  pwr_data and pwr_bin are valid this cycle.
- pwr_data  out  2*DATA_WIDTH+1  unsigned I²+Q².
- pwr_bin  out  log2(N)  bin index of pwr_data.
- peak_valid  out  1  one-cycle pulse; peak_bin and peak_power are valid.
- peak_bin  out  log2(N)  index of the maximum-power bin.
- peak_power  out  2*DATA_WIDTH+1  power of that bin.
- frame_err  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, the bin counter is 0, max is 0, and the FSM is IDLE. Reset mid-frame discards the frame; no peak_valid or frame_err is issued for it.
- Pipeline stage 1: register I, Q, flag and the arrival index.
- Pipeline stage 2: compute signed squares I² and Q², each 2*DW bits, unsigned result.
- Pipeline stage 3: sum the two squares at 2*DW+1 bits with no truncation or saturation.
  - Maximum value is 2·(−2^(DW−1))² = 2^(2DW−1); it fits.
- Streaming latency: pwr_valid is asserted exactly 3 cycles after the in_fft_data_flag cycle of the same bin. pwr_bin is that bin's (optionally bit-reversed) index.
- Bin counter: increments on every flagged input. It is reset to 0 at frame start and at abort.
- FSM states:
  - IDLE: waits for the first flagged input, then enters ACCUM with count = 0.
  - ACCUM: accepts one bin per cycle.
    - The flag dropping before N bins are received sends the FSM to ABORT.
    - When the N-th bin (count = N−1) is accepted, the FSM goes to DRAIN.
  - DRAIN: waits for the last bin to leave the 3-stage pipeline, then goes to REPORT.
    - A flag arriving during DRAIN starts the next frame's counter. The pipeline continues, but peak tracking for the new frame starts after the REPORT pulse. No input is lost.
  - REPORT: holds for one cycle; peak_valid = 1 with the frame's max; the tracker is cleared. Next state is ACCUM if a new frame is in progress, otherwise IDLE.
  - ABORT: holds for one cycle; frame_err = 1, the tracker is cleared, and the FSM returns to IDLE. Bins already in the pipeline still appear on pwr_*.
- Peak tracking runs on pipeline stage 3 output and updates on a strictly greater power.
  - Ties keep the earliest bin.
  - With all-zero input: peak_bin = first eligible bin (0, or 1 when SKIP_DC = 1) and peak_power = 0. The tracker initialises to the first eligible bin.
- peak_bin and peak_power hold their values until the next REPORT. peak_valid and frame_err are single-cycle pulses and are never high together.
- Back-to-back frames with the flag continuously high for k·N cycles produce k REPORT pulses with no frame_err.
- Index wrap: the counter is log2(N) bits and wraps from N−1 to 0 only at frame boundaries.

Test Plan:
- Reset with a frame in flight: drive 10 bins, then pulse rst_n low → all outputs 0 immediately. Then send a full clean frame → exactly one peak_valid and no frame_err.
- N=64 frame, all bins {0,0} except bin 17 = {I=3, Q=−4} → peak_valid 3–4 cycles after the last bin, peak_bin = 17, peak_power = 25. pwr_data = 25 at pwr_bin = 17 exactly 3 cycles after that input.
- Extreme values, bin 5 = {−128, −128} → pwr_data = 32768 with no overflow, and peak_power = 32768.
- SKIP_DC=1, bin 0 = {100,0}, bin 40 = {10,0}, bins 40 and 41 equal → peak_bin = 40, peak_power = 100. With SKIP_DC=0 → peak_bin = 0, peak_power = 10000.
- Flag drops after 30 bins → one frame_err pulse, no peak_valid, FSM in IDLE. 30 pwr_valid pulses still emitted.
- Flag held high for 128 cycles at N=64 → two peak_valid pulses 64 cycles apart, each with the correct per-frame maximum. BIT_REVERSE=1 run with a peak at arrival index 1 → peak_bin = 32.
